stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Sequences the BCD stopwatch timer (s / 100ms / 10ms digits). Generates its ctrl code
//  (01 clear, 10 run, 00 hold) and the slow count tick. Turns start/lap/clear buttons into
//  a run/pause/overflow state machine with lap capture.
//  Sits between the board buttons and the timer; its disp_* outputs feed the 7-seg driver.
// PARAMETERS
//  TICK_HALF  250000  clk cycles per half period of slowclk (full period = 2*TICK_HALF)
//  MAX_S      9       seconds digit value at which overflow is declared
//  MAX_MS     9       100ms digit value at which overflow is declared
//  MAX_MMS    8       10ms digit value at which overflow is declared (timer steps by 2)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  btn_start  in   1  start/pause button, asynchronous level
//  btn_lap    in   1  lap button, asynchronous level
//  btn_clear  in   1  clear button, asynchronous level
//  t_s        in   4  timer seconds digit, BCD
//  t_ms       in   4  timer 100ms digit, BCD
//  t_mms      in   4  timer 10ms digit, BCD
//  ctrl       out  2  timer control: 01 clear, 10 run, 00 hold
//  slowclk    out  1  square-wave count tick to timer; toggles only in RUN
//  disp_s     out  4  displayed seconds digit (live or lap)
//  disp_ms    out  4  displayed 100ms digit
//  disp_mms   out  4  displayed 10ms digit
//  lap_view   out  1  1 = disp_* show the captured lap value
//  ovf        out  1  1 = overflow reached, timer frozen
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, ctrl=01, slowclk=0, prescaler=0, lap regs=0,
//   lap_view=0, ovf=0, all sync/edge flops=0. disp_* then equal the t_* inputs.
//  Buttons: each goes through a 2-flop synchroniser and rising-edge detect. Result is a
//   1-cycle pulse. ctrl/state change after the 3rd rising clk edge at which the button is
//   sampled high. A held button produces exactly one pulse.
//  Pulse priority when several arrive in the same cycle: clear > start > lap.
//   Lower-priority pulses in that cycle are discarded.
//  States, ctrl decoded combinationally from state:
//   IDLE  ctrl=01 -> start: RUN.
//   RUN   ctrl=10 -> start: PAUSE; overflow: OVF. clear is ignored.
//   PAUSE ctrl=00 -> start: RUN; clear: IDLE.
//   OVF   ctrl=00, ovf=1 -> clear: IDLE. start and lap are ignored.
//  Overflow: in RUN, when t_s==MAX_S && t_ms==MAX_MS && t_mms>=MAX_MMS, go to OVF on the
//   next edge. Digit compares are unsigned 4-bit.
//  slowclk:
//   - On any transition into RUN, prescaler=0 and slowclk=0.
//   - In RUN, prescaler counts 0..TICK_HALF-1; at wrap, slowclk toggles. First rising edge
//     occurs 2*TICK_HALF cycles after RUN entry.
//   - Outside RUN, prescaler and slowclk hold their value. Leaving RUN forces slowclk=0.
//  Lap:
//   - lap pulse in RUN with lap_view=0: capture t_* into lap regs, set lap_view=1.
//   - lap pulse in RUN with lap_view=1: clear lap_view (back to live). Lap regs are kept.
//   - lap in IDLE/PAUSE/OVF: ignored.
//   - Entering IDLE clears lap_view and the lap regs.
//  disp_*: lap regs when lap_view=1, else t_* (combinational mux, zero latency).
//  Reset mid-operation: immediate return to IDLE/ctrl=01. Any pending pulses are lost.
// STRUCTURE
//  Shared package stopwatch_pkg: state encoding (IDLE/RUN/PAUSE/OVF, 2 bits) and the ctrl
//   code constants CTRL_CLEAR=2'b01, CTRL_RUN=2'b10, CTRL_HOLD=2'b00 used by timer and
//   controller.
//  One sub-module: btn_pulse (2-flop sync + rising-edge detect), instantiated three times.
//  Prescaler, FSM, lap regs and display mux live in stopwatch_ctrl.
// TESTING (TICK_HALF=4 in bench; behavioural timer model attached)
//  1 Reset then idle 20 cycles -> ctrl=01, slowclk=0, disp=0.0.0, ovf=0, lap_view=0.
//  2 start held 10 cycles -> one pulse only. ctrl=10 after 3rd edge sampling high.
//    First slowclk rise 8 cycles after RUN entry, then every 8 cycles.
//  3 RUN, lap at t=1.4.6 -> lap_view=1 and disp frozen at 1.4.6 while the timer advances.
//    Second lap -> lap_view=0, disp live.
//  4 RUN, start+clear in same cycle -> clear wins but is ignored in RUN: state stays RUN.
//    In PAUSE the same stimulus -> IDLE, ctrl=01, lap_view=0.
//  5 Run until timer reads 9.9.8 -> OVF next edge, ctrl=00, ovf=1, slowclk=0.
//    start/lap ignored; clear -> IDLE.
//  6 rst_n low mid-RUN with slowclk=1 -> immediately ctrl=01, slowclk=0, state IDLE,
//    before the next clk edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller and the BCD timer it drives:
// controller state encoding and the timer control codes.
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_OVF   = 2'd3;

  localparam logic [1:0] CTRL_CLEAR = 2'b01;
  localparam logic [1:0] CTRL_RUN   = 2'b10;
  localparam logic [1:0] CTRL_HOLD  = 2'b00;

  function automatic logic [1:0] state_ctrl(state_t s);
    logic [1:0] c;
    case (s)
      ST_IDLE: c = CTRL_CLEAR;
      ST_RUN:  c = CTRL_RUN;
      default: c = CTRL_HOLD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_pulse.sv
// Brings an asynchronous button level into the clk domain and emits a single-cycle
// pulse on its rising edge; holding the button down yields only one pulse.
module btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button pulses drive the IDLE/RUN/PAUSE/OVF machine, which in turn
// produces the timer control code, the slow count tick and the lap-capable display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_HALF = 250000,
  parameter int MAX_S     = 9,
  parameter int MAX_MS    = 9,
  parameter int MAX_MMS   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic [3:0] t_s,
  input  logic [3:0] t_ms,
  input  logic [3:0] t_mms,
  output logic [1:0] ctrl,
  output logic       slowclk,
  output logic [3:0] disp_s,
  output logic [3:0] disp_ms,
  output logic [3:0] disp_mms,
  output logic       lap_view,
  output logic       ovf
);

  localparam int PW = (TICK_HALF > 1) ? $clog2(TICK_HALF) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_HALF - 1);
  localparam logic [3:0] MAX_S_D   = 4'(MAX_S);
  localparam logic [3:0] MAX_MS_D  = 4'(MAX_MS);
  localparam logic [3:0] MAX_MMS_D = 4'(MAX_MMS);

  state_t        state;
  state_t        state_nxt;
  logic          start_p;
  logic          lap_p;
  logic          clear_p;
  logic          start_ev;
  logic          lap_ev;
  logic          clear_ev;
  logic          at_max;
  logic          run_entry;
  logic          lap_toggle;
  logic [PW-1:0] presc;
  logic          first_wrap;
  logic [3:0]    lap_s;
  logic [3:0]    lap_ms;
  logic [3:0]    lap_mms;

  btn_pulse u_start (.clk(clk), .rst_n(rst_n), .btn(btn_start), .pulse(start_p));
  btn_pulse u_lap   (.clk(clk), .rst_n(rst_n), .btn(btn_lap),   .pulse(lap_p));
  btn_pulse u_clear (.clk(clk), .rst_n(rst_n), .btn(btn_clear), .pulse(clear_p));

  // clear > start > lap: a higher-priority pulse swallows the others in the same cycle.
  assign clear_ev = clear_p;
  assign start_ev = start_p & ~clear_p;
  assign lap_ev   = lap_p & ~start_p & ~clear_p;

  assign at_max = (t_s == MAX_S_D) && (t_ms == MAX_MS_D) && (t_mms >= MAX_MMS_D);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_ev) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (at_max)        state_nxt = ST_OVF;
        else if (start_ev) state_nxt = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (clear_ev)      state_nxt = ST_IDLE;
        else if (start_ev) state_nxt = ST_RUN;
      end
      default: begin
        if (clear_ev) state_nxt = ST_IDLE;
      end
    endcase
  end

  assign run_entry  = (state_nxt == ST_RUN) && (state != ST_RUN);
  assign lap_toggle = (state == ST_RUN) && !at_max && lap_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // The first prescaler wrap after entering RUN is swallowed so the tick stays low for a
  // full period before its first rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      slowclk    <= 1'b0;
      first_wrap <= 1'b0;
    end else if (run_entry) begin
      presc      <= '0;
      slowclk    <= 1'b0;
      first_wrap <= 1'b1;
    end else if (state == ST_RUN && state_nxt == ST_RUN) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        if (first_wrap) first_wrap <= 1'b0;
        else            slowclk    <= ~slowclk;
      end else begin
        presc <= presc + PW'(1);
      end
    end else if (state == ST_RUN) begin
      slowclk <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_view <= 1'b0;
      lap_s    <= '0;
      lap_ms   <= '0;
      lap_mms  <= '0;
    end else if (state_nxt == ST_IDLE) begin
      lap_view <= 1'b0;
      lap_s    <= '0;
      lap_ms   <= '0;
      lap_mms  <= '0;
    end else if (lap_toggle) begin
      if (!lap_view) begin
        lap_view <= 1'b1;
        lap_s    <= t_s;
        lap_ms   <= t_ms;
        lap_mms  <= t_mms;
      end else begin
        lap_view <= 1'b0;
      end
    end
  end

  assign ctrl     = state_ctrl(state);
  assign ovf      = (state == ST_OVF);
  assign disp_s   = lap_view ? lap_s   : t_s;
  assign disp_ms  = lap_view ? lap_ms  : t_ms;
  assign disp_mms = lap_view ? lap_mms : t_mms;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a behavioural timer plus a reference model of the controller,
// exercised by directed sequences, a vector table and randomized button activity.
module tb_stopwatch_ctrl;

  localparam int TH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_lap = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] t_s;
  logic [3:0] t_ms;
  logic [3:0] t_mms;
  logic [1:0] ctrl;
  logic       slowclk;
  logic [3:0] disp_s;
  logic [3:0] disp_ms;
  logic [3:0] disp_mms;
  logic       lap_view;
  logic       ovf;

  int n_checks = 0;
  int n_fail = 0;

  // Timer held as a count of 10ms units; the DUT sees it as three BCD digits.
  int tm_cs = 0;
  logic prev_slow = 1'b0;

  assign t_s   = 4'(tm_cs / 100);
  assign t_ms  = 4'((tm_cs / 10) % 10);
  assign t_mms = 4'(tm_cs % 10);

  stopwatch_ctrl #(.TICK_HALF(TH)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .t_s(t_s), .t_ms(t_ms), .t_mms(t_mms),
    .ctrl(ctrl), .slowclk(slowclk),
    .disp_s(disp_s), .disp_ms(disp_ms), .disp_mms(disp_mms),
    .lap_view(lap_view), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_OVF} mode_e;

  mode_e      m_mode;
  int         m_run_cycles;
  bit         m_lap_view;
  int         m_lap_cs;
  logic [3:0] hs, hl, hc;

  function automatic logic [11:0] bcd(int cs);
    return {4'(cs / 100), 4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  task automatic modelReset();
    m_mode = M_IDLE;
    m_run_cycles = 0;
    m_lap_view = 0;
    m_lap_cs = 0;
    hs = '0;
    hl = '0;
    hc = '0;
  endtask

  // A press acts at the third edge that samples it high: sampled high two edges ago,
  // low three edges ago.
  task automatic modelEdge();
    bit st, lp, cl, top;
    mode_e prev;
    if (!rst_n) begin
      modelReset();
    end else begin
      hs = {hs[2:0], btn_start};
      hl = {hl[2:0], btn_lap};
      hc = {hc[2:0], btn_clear};
      st = hs[2] & ~hs[3];
      lp = hl[2] & ~hl[3];
      cl = hc[2] & ~hc[3];
      if (cl) begin st = 0; lp = 0; end
      else if (st) lp = 0;
      top = (tm_cs >= 998);
      prev = m_mode;
      case (m_mode)
        M_IDLE:  if (st) m_mode = M_RUN;
        M_RUN: begin
          if (top) m_mode = M_OVF;
          else if (st) m_mode = M_PAUSE;
          else if (lp) begin
            if (m_lap_view) m_lap_view = 0;
            else begin m_lap_view = 1; m_lap_cs = tm_cs; end
          end
        end
        M_PAUSE: begin
          if (cl) m_mode = M_IDLE;
          else if (st) m_mode = M_RUN;
        end
        M_OVF:   if (cl) m_mode = M_IDLE;
      endcase
      if (m_mode == M_RUN) m_run_cycles = (prev == M_RUN) ? m_run_cycles + 1 : 0;
      if (m_mode == M_IDLE) begin m_lap_view = 0; m_lap_cs = 0; end
    end
  endtask

  task automatic timerUpdate();
    if (ctrl == 2'b01) tm_cs = 0;
    else if (ctrl == 2'b10 && slowclk && !prev_slow) tm_cs = (tm_cs + 2) % 1000;
    prev_slow = slowclk;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    logic [1:0] ec;
    bit es;
    ec = (m_mode == M_IDLE) ? 2'b01 : (m_mode == M_RUN) ? 2'b10 : 2'b00;
    es = (m_mode == M_RUN) && (m_run_cycles >= 2 * TH) && ((m_run_cycles / TH) % 2 == 0);
    checkOutput("model_ctrl", ctrl, ec);
    checkOutput("model_slowclk", slowclk, es);
    checkOutput("model_lap_view", lap_view, m_lap_view);
    checkOutput("model_ovf", ovf, m_mode == M_OVF);
    checkOutput("model_disp", {disp_s, disp_ms, disp_mms}, bcd(m_lap_view ? m_lap_cs : tm_cs));
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    timerUpdate();
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(logic st, logic lp, logic cl);
    btn_start = st;
    btn_lap = lp;
    btn_clear = cl;
  endtask

  task automatic press(logic st, logic lp, logic cl);
    applyStimulus(st, lp, cl);
    step();
    applyStimulus(0, 0, 0);
    repeat (4) step();
  endtask

  task automatic waitTimer(int target, int budget, string name);
    int n = 0;
    while (tm_cs != target && n < budget) begin
      step();
      n++;
    end
    checkOutput(name, tm_cs, target);
  endtask

  typedef struct {
    logic st, lp, cl;
    logic [1:0] ctrl;
    logic lv;
  } vec_t;

  vec_t vecs[16];
  int rises[$];

  initial begin
    logic ps;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 2'b10, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0};

    $display("[TB] reset and idle");
    modelReset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    checkOutput("idle_ctrl", ctrl, 2'b01);
    checkOutput("idle_slowclk", slowclk, 1'b0);
    checkOutput("idle_disp", {disp_s, disp_ms, disp_mms}, 12'h000);
    checkOutput("idle_ovf", ovf, 1'b0);
    checkOutput("idle_lap_view", lap_view, 1'b0);

    $display("[TB] held start, slowclk cadence");
    applyStimulus(1, 0, 0);
    ps = slowclk;
    for (int i = 1; i <= 30; i++) begin
      if (i == 11) applyStimulus(0, 0, 0);
      step();
      if (i == 2) checkOutput("start_before_3rd_edge", ctrl, 2'b01);
      if (i == 3) checkOutput("start_at_3rd_edge", ctrl, 2'b10);
      if (slowclk && !ps) rises.push_back(i);
      ps = slowclk;
    end
    checkOutput("held_start_single_pulse", ctrl, 2'b10);
    checkOutput("slowclk_rise_count", rises.size(), 3);
    if (rises.size() >= 2) begin
      checkOutput("first_rise_after_entry", rises[0] - 3, 2 * TH);
      checkOutput("rise_period", rises[1] - rises[0], 2 * TH);
    end

    $display("[TB] lap capture at 1.4.6");
    waitTimer(146, 800, "reach_1_4_6");
    press(0, 1, 0);
    repeat (20) step();
    checkOutput("lap_view_set", lap_view, 1'b1);
    checkOutput("lap_frozen_disp", {disp_s, disp_ms, disp_mms}, 12'h146);
    checkOutput("timer_moved_on", tm_cs > 146, 1'b1);
    press(0, 1, 0);
    checkOutput("lap_view_cleared", lap_view, 1'b0);
    checkOutput("live_disp", {disp_s, disp_ms, disp_mms}, bcd(tm_cs));

    $display("[TB] start+clear priority");
    press(1, 0, 1);
    checkOutput("clear_ignored_in_run", ctrl, 2'b10);
    press(0, 1, 0);
    press(1, 0, 0);
    checkOutput("paused", ctrl, 2'b00);
    checkOutput("lap_kept_in_pause", lap_view, 1'b1);
    press(1, 0, 1);
    checkOutput("pause_clear_ctrl", ctrl, 2'b01);
    checkOutput("pause_clear_lap_view", lap_view, 1'b0);

    $display("[TB] vector table");
    for (int v = 0; v < 16; v++) begin
      press(vecs[v].st, vecs[v].lp, vecs[v].cl);
      checkOutput($sformatf("vec%0d_ctrl", v), ctrl, vecs[v].ctrl);
      checkOutput($sformatf("vec%0d_lap_view", v), lap_view, vecs[v].lv);
      checkOutput($sformatf("vec%0d_ovf", v), ovf, 1'b0);
    end

    $display("[TB] overflow");
    press(1, 0, 0);
    waitTimer(998, 4500, "reach_9_9_8");
    step();
    checkOutput("ovf_flag", ovf, 1'b1);
    checkOutput("ovf_ctrl", ctrl, 2'b00);
    checkOutput("ovf_slowclk", slowclk, 1'b0);
    press(1, 0, 0);
    press(0, 1, 0);
    checkOutput("ovf_ignores_start_lap", ovf, 1'b1);
    checkOutput("ovf_disp_frozen", {disp_s, disp_ms, disp_mms}, 12'h998);
    press(0, 0, 1);
    checkOutput("ovf_clear_ctrl", ctrl, 2'b01);
    checkOutput("ovf_clear_flag", ovf, 1'b0);

    $display("[TB] async reset mid-run");
    press(1, 0, 0);
    begin
      int n = 0;
      while (!slowclk && n < 50) begin step(); n++; end
    end
    checkOutput("slowclk_high_before_reset", slowclk, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_ctrl_immediate", ctrl, 2'b01);
    checkOutput("reset_slowclk_immediate", slowclk, 1'b0);
    checkModel();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();

    $display("[TB] randomized buttons");
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 5) == 0) btn_lap = ~btn_lap;
      if ($urandom_range(0, 15) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        modelReset();
        checkModel();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
